// File: rtl/snake_motion.sv
// -----------------------------------------------------------------------------
// snake_motion
//
// Snake movement engine. Each accepted game tick advances the head one cell in
// the requested heading and wraps at the grid edges. The body is a shift
// register of cell coordinates: segment 0 is the head. The block handles
// growth, raises a sticky self-collision flag, and answers registered
// per-cell occupancy queries for the pixel renderer.
//
// Build option:
//   SNAKE_REVERSE_GUARD_EN - when defined, a 180-degree turn request is
//                            ignored and the snake keeps going straight.
//                            When undefined, the reversal is applied as-is.
//
// Ports:
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   tick       : one-cycle step strobe
//   direction  : requested heading (00 right, 01 down, 10 left, 11 up)
//   grow       : pulse, requests +1 length on the next step
//   qry_x/y    : cell to test against the body
//   head_x/y   : current head cell
//   length     : current live segment count
//   heading    : last applied heading
//   step_done  : one-cycle pulse the cycle after an accepted step
//   self_hit   : sticky, the snake ran into its own body
//   qry_hit    : queried cell is occupied by any live segment (1-cycle latency)
//   qry_head   : queried cell is the head (1-cycle latency)
// -----------------------------------------------------------------------------
module snake_motion #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int X_W      = 5,
    parameter int Y_W      = 5,
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = 5,
    parameter int INIT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [1:0]       direction,
    input  logic             grow,
    input  logic [X_W-1:0]   qry_x,
    input  logic [Y_W-1:0]   qry_y,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    output logic [LEN_W-1:0] length,
    output logic [1:0]       heading,
    output logic             step_done,
    output logic             self_hit,
    output logic             qry_hit,
    output logic             qry_head
);

    localparam logic [X_W-1:0]   X_MAX     = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(GRID_H - 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_RESET = LEN_W'(INIT_LEN);

    // Body state
    logic [X_W-1:0]   seg_x_reg [MAX_LEN];
    logic [Y_W-1:0]   seg_y_reg [MAX_LEN];
    logic [LEN_W-1:0] length_reg;
    logic [1:0]       heading_reg;
    logic             grow_pend_reg;
    logic             self_hit_reg;
    logic             step_done_reg;
    logic             qry_hit_reg;
    logic             qry_head_reg;

    // Step evaluation
    logic [1:0]       dir_next;
    logic [X_W-1:0]   head_x_next;
    logic [Y_W-1:0]   head_y_next;
    logic             eff_grow;
    logic [LEN_W-1:0] cmp_len;
    logic [MAX_LEN-1:0] hit_vec;
    logic [MAX_LEN-1:0] qry_vec;
    logic             collision;
    logic             step_accept;

    assign step_accept = tick & ~self_hit_reg;

    // Heading actually used for this step.
    always_comb begin
        dir_next = direction;
`ifdef SNAKE_REVERSE_GUARD_EN
        // A 180-degree request would drive the head straight into seg 1;
        // keep going straight instead.
        if (direction == (heading_reg ^ 2'b10)) begin
            dir_next = heading_reg;
        end
`endif
    end

    // Next head cell. Wrap is an explicit compare because the grid need not
    // be a power of two.
    always_comb begin
        head_x_next = seg_x_reg[0];
        head_y_next = seg_y_reg[0];
        case (dir_next)
            2'b00: head_x_next = (seg_x_reg[0] == X_MAX) ? '0 : seg_x_reg[0] + X_W'(1);
            2'b01: head_y_next = (seg_y_reg[0] == Y_MAX) ? '0 : seg_y_reg[0] + Y_W'(1);
            2'b10: head_x_next = (seg_x_reg[0] == '0) ? X_MAX : seg_x_reg[0] - X_W'(1);
            default: head_y_next = (seg_y_reg[0] == '0) ? Y_MAX : seg_y_reg[0] - Y_W'(1);
        endcase
    end

    // Growth request is dropped silently once the body is full.
    assign eff_grow = (grow_pend_reg | grow) & (length_reg < LEN_MAX);

    // The tail vacates its cell on a normal step, so it only counts as an
    // obstacle when the snake is growing.
    assign cmp_len = eff_grow ? length_reg : length_reg - LEN_W'(1);

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg_cmp
            assign hit_vec[gi] = (LEN_W'(gi) < cmp_len) &&
                                 (seg_x_reg[gi] == head_x_next) &&
                                 (seg_y_reg[gi] == head_y_next);
            assign qry_vec[gi] = (LEN_W'(gi) < length_reg) &&
                                 (seg_x_reg[gi] == qry_x) &&
                                 (seg_y_reg[gi] == qry_y);
        end
    endgenerate

    assign collision = |hit_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    seg_x_reg[i] <= X_W'(GRID_W / 2 - i);
                    seg_y_reg[i] <= Y_W'(GRID_H / 2);
                end else begin
                    seg_x_reg[i] <= '0;
                    seg_y_reg[i] <= '0;
                end
            end
            length_reg    <= LEN_RESET;
            heading_reg   <= 2'b00;
            grow_pend_reg <= 1'b0;
            self_hit_reg  <= 1'b0;
            step_done_reg <= 1'b0;
            qry_hit_reg   <= 1'b0;
            qry_head_reg  <= 1'b0;
        end else begin
            // Queries always see the state as it was in the sampling cycle.
            qry_hit_reg   <= |qry_vec;
            qry_head_reg  <= (seg_x_reg[0] == qry_x) && (seg_y_reg[0] == qry_y);
            step_done_reg <= step_accept;

            if (step_accept) begin
                // The grow request (latched or same-cycle) is consumed here,
                // even if the step ends in a collision.
                grow_pend_reg <= 1'b0;
                if (collision) begin
                    // Body, length and heading stay frozen at the crash point.
                    self_hit_reg <= 1'b1;
                end else begin
                    for (int i = MAX_LEN - 1; i >= 1; i--) begin
                        seg_x_reg[i] <= seg_x_reg[i-1];
                        seg_y_reg[i] <= seg_y_reg[i-1];
                    end
                    seg_x_reg[0] <= head_x_next;
                    seg_y_reg[0] <= head_y_next;
                    // Growing just extends the live window over the old tail.
                    length_reg   <= length_reg + LEN_W'(eff_grow);
                    heading_reg  <= dir_next;
                end
            end else if (grow) begin
                grow_pend_reg <= 1'b1;
            end
        end
    end

    assign head_x    = seg_x_reg[0];
    assign head_y    = seg_y_reg[0];
    assign length    = length_reg;
    assign heading   = heading_reg;
    assign step_done = step_done_reg;
    assign self_hit  = self_hit_reg;
    assign qry_hit   = qry_hit_reg;
    assign qry_head  = qry_head_reg;

endmodule

// File: tb/tb_snake_motion.sv
// -----------------------------------------------------------------------------
// tb_snake_motion
//
// Self-checking bench for snake_motion with default parameters. Every driven
// cycle pushes an expected output record into a queue; a monitor pops one
// record per clock and compares it with the DUT outputs. Expected records
// come either from a hand-written vector table or from a small behavioural
// model of the snake. A few directed sequences add explicit end-state checks.
// -----------------------------------------------------------------------------
module tb_snake_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] direction = 2'b00;
    logic       grow = 1'b0;
    logic [4:0] qry_x = '0;
    logic [4:0] qry_y = '0;
    logic [4:0] head_x;
    logic [4:0] head_y;
    logic [4:0] length;
    logic [1:0] heading;
    logic       step_done;
    logic       self_hit;
    logic       qry_hit;
    logic       qry_head;

    always #5 clk = ~clk;

    snake_motion dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .direction (direction),
        .grow      (grow),
        .qry_x     (qry_x),
        .qry_y     (qry_y),
        .head_x    (head_x),
        .head_y    (head_y),
        .length    (length),
        .heading   (heading),
        .step_done (step_done),
        .self_hit  (self_hit),
        .qry_hit   (qry_hit),
        .qry_head  (qry_head)
    );

    typedef struct {
        int hx; int hy; int len; int hdg;
        int sd; int sh; int qh; int qhd;
    } exp_t;

    typedef struct {
        int t; int d; int g; int qx; int qy;
        exp_t e;
    } vec_t;

    exp_t exp_q[$];
    exp_t zero_e;
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   sd_cnt   = 0;
    int   txn      = 0;

    // ---------------- behavioural model ----------------
    int mx[16];
    int my[16];
    int mlen;
    int mhdg;
    int mpend;
    int mhit;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            mx[i] = (i < 3) ? 16 - i : 0;
            my[i] = (i < 3) ? 12 : 0;
        end
        mlen = 3; mhdg = 0; mpend = 0; mhit = 0;
    endfunction

    function automatic exp_t model_step(int t, int d, int g, int qx, int qy);
        exp_t e;
        int qh = 0;
        int qhd = 0;
        int sd = 0;
        int nd, nx, ny, eg, lim;
        int hit = 0;
        for (int i = 0; i < mlen; i++)
            if (mx[i] == qx && my[i] == qy) qh = 1;
        if (mx[0] == qx && my[0] == qy) qhd = 1;
        if (t != 0 && mhit == 0) begin
            sd = 1;
            nd = d;
`ifdef SNAKE_REVERSE_GUARD_EN
            if (d == (mhdg ^ 2)) nd = mhdg;
`endif
            nx = mx[0];
            ny = my[0];
            if (nd == 0) nx = (nx == 31) ? 0 : nx + 1;
            else if (nd == 1) ny = (ny == 23) ? 0 : ny + 1;
            else if (nd == 2) nx = (nx == 0) ? 31 : nx - 1;
            else ny = (ny == 0) ? 23 : ny - 1;
            eg  = ((mpend != 0 || g != 0) && mlen < 16) ? 1 : 0;
            lim = (eg != 0) ? mlen : mlen - 1;
            for (int i = 0; i < lim; i++)
                if (mx[i] == nx && my[i] == ny) hit = 1;
            if (hit != 0) begin
                mhit = 1;
            end else begin
                for (int i = 15; i >= 1; i--) begin
                    mx[i] = mx[i-1];
                    my[i] = my[i-1];
                end
                mx[0] = nx; my[0] = ny;
                mlen = mlen + eg;
                mhdg = nd;
            end
            mpend = 0;
        end else if (g != 0) begin
            mpend = 1;
        end
        e = '{mx[0], my[0], mlen, mhdg, sd, mhit, qh, qhd};
        return e;
    endfunction

    // ---------------- checking ----------------
    function automatic void chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s txn=%0d actual=%0d expected=%0d", nm, txn, act, expv);
        end
    endfunction

    // Monitor: one expected record per clock, sampled 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (step_done) sd_cnt++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                txn++;
                chk("head_x",    head_x,    mon_e.hx);
                chk("head_y",    head_y,    mon_e.hy);
                chk("length",    length,    mon_e.len);
                chk("heading",   heading,   mon_e.hdg);
                chk("step_done", step_done, mon_e.sd);
                chk("self_hit",  self_hit,  mon_e.sh);
                chk("qry_hit",   qry_hit,   mon_e.qh);
                chk("qry_head",  qry_head,  mon_e.qhd);
                $display("txn %0d: head=(%0d,%0d) len=%0d hdg=%0d sd=%0d hit=%0d q=%0d/%0d",
                         txn, head_x, head_y, length, heading, step_done, self_hit,
                         qry_hit, qry_head);
            end
        end
    end

    // Drive one cycle at the falling edge, queue its expectation, return just
    // after the following rising edge.
    task automatic cyc(input int r, input int t, input int d, input int g,
                       input int qx, input int qy, input int use_tab, input exp_t tab);
        exp_t e;
        @(negedge clk);
        rst       = r[0];
        tick      = t[0];
        direction = d[1:0];
        grow      = g[0];
        qry_x     = qx[4:0];
        qry_y     = qy[4:0];
        if (r != 0) begin
            model_reset();
            e = '{mx[0], my[0], mlen, mhdg, 0, 0, 0, 0};
        end else begin
            e = model_step(t, d, g, qx, qy);
        end
        if (use_tab != 0) e = tab;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic step(input int t, input int d, input int g, input int qx, input int qy);
        cyc(0, t, d, g, qx, qy, 0, zero_e);
    endtask

    task automatic do_reset(input int t, input int g);
        cyc(1, t, 0, g, 0, 0, 0, zero_e);
    endtask

    vec_t vecs[13];
    int   sd_base;

    initial begin
        // Hand-computed vectors starting from the reset state
        // head (16,12), (15,12), (14,12), length 3, heading right.
        vecs[0]  = '{0, 0, 0, 16, 12, '{16, 12, 3, 0, 0, 0, 1, 1}};
        vecs[1]  = '{0, 0, 0, 14, 12, '{16, 12, 3, 0, 0, 0, 1, 0}};
        vecs[2]  = '{0, 0, 0, 13, 12, '{16, 12, 3, 0, 0, 0, 0, 0}};
        vecs[3]  = '{0, 0, 0,  0,  0, '{16, 12, 3, 0, 0, 0, 0, 0}};
        vecs[4]  = '{1, 0, 0, 16, 12, '{17, 12, 3, 0, 1, 0, 1, 1}};
        vecs[5]  = '{0, 0, 0, 17, 12, '{17, 12, 3, 0, 0, 0, 1, 1}};
        vecs[6]  = '{1, 1, 1, 15, 12, '{17, 13, 4, 1, 1, 0, 1, 0}};
        vecs[7]  = '{0, 0, 0, 15, 12, '{17, 13, 4, 1, 0, 0, 1, 0}};
        vecs[8]  = '{0, 0, 1,  0,  0, '{17, 13, 4, 1, 0, 0, 0, 0}};
        vecs[9]  = '{1, 2, 0, 16, 13, '{16, 13, 5, 2, 1, 0, 0, 0}};
        vecs[10] = '{0, 0, 0, 16, 13, '{16, 13, 5, 2, 0, 0, 1, 1}};
        vecs[11] = '{1, 3, 0, 15, 12, '{16, 13, 5, 2, 1, 1, 1, 0}};
        vecs[12] = '{1, 0, 0, 16, 12, '{16, 13, 5, 2, 0, 1, 1, 0}};

        repeat (2) @(posedge clk);
        do_reset(0, 0);
        for (int i = 0; i < 13; i++)
            cyc(0, vecs[i].t, vecs[i].d, vecs[i].g, vecs[i].qx, vecs[i].qy, 1, vecs[i].e);

        // rst wins over tick and grow in the same cycle.
        do_reset(1, 1);
        step(0, 0, 0, 16, 12);

        // Right-edge wrap: 16 steps from x=16 lands at x=0.
        do_reset(0, 0);
        sd_base = sd_cnt;
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 12);
        #2;
        chk("wrap_r_x", head_x, 0);
        chk("wrap_r_y", head_y, 12);
        chk("wrap_r_sd_count", sd_cnt - sd_base, 16);
        chk("wrap_r_self_hit", self_hit, 0);

        // Up-edge wrap: 13 steps from y=12 goes through 0 to 23.
        for (int i = 0; i < 13; i++) step(1, 3, 0, 0, 0);
        #2;
        chk("wrap_u_x", head_x, 0);
        chk("wrap_u_y", head_y, 23);
        chk("wrap_u_heading", heading, 3);

        // Grow: pulse, then step; tail cell (14,12) stays occupied.
        do_reset(0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 14, 12);
        step(0, 0, 0, 14, 12);
        #2;
        chk("grow_len", length, 4);
        chk("grow_tail_kept", qry_hit, 1);
        for (int i = 0; i < 14; i++) step(1, 0, 1, 0, 0);
        #2;
        chk("grow_saturate", length, 16);
        step(1, 0, 1, 0, 0);
        #2;
        chk("grow_full_drop", length, 16);

        // Self collision: grow to 5, then down, left, up.
        do_reset(0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        #2;
        chk("coll_pre_hit", self_hit, 0);
        step(1, 3, 0, 0, 0);
        #2;
        chk("coll_hit", self_hit, 1);
        chk("coll_head_x", head_x, 17);
        chk("coll_head_y", head_y, 13);
        sd_base = sd_cnt;
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        #2;
        chk("coll_no_step_done", sd_cnt - sd_base, 0);

        // Reversal while heading right.
        do_reset(0, 0);
        step(1, 2, 0, 0, 0);
        #2;
`ifdef SNAKE_REVERSE_GUARD_EN
        chk("rev_head_x", head_x, 17);
        chk("rev_heading", heading, 0);
        chk("rev_self_hit", self_hit, 0);
        step(0, 0, 0, 15, 12);
`else
        chk("rev_self_hit", self_hit, 1);
        chk("rev_head_x", head_x, 16);
        step(0, 0, 0, 14, 12);
`endif
        #2;
        chk("rev_qry_seg2", qry_hit, 1);
        step(0, 0, 0, 5, 5);
        #2;
        chk("rev_qry_free", qry_hit, 0);

        // Random traffic against the model, queries biased onto body cells.
        do_reset(0, 0);
        for (int i = 0; i < 300; i++) begin
            int r, t, d, g, qx, qy, k;
            r = ($urandom_range(0, 39) == 0) ? 1 : 0;
            t = $urandom_range(0, 1);
            d = $urandom_range(0, 3);
            g = ($urandom_range(0, 5) == 0) ? 1 : 0;
            if ($urandom_range(0, 1) == 1) begin
                k  = $urandom_range(0, mlen - 1);
                qx = mx[k];
                qy = my[k];
            end else begin
                qx = $urandom_range(0, 31);
                qy = $urandom_range(0, 23);
            end
            cyc(r, t, d, g, qx, qy, 0, zero_e);
        end

        @(negedge clk);
        tick = 1'b0;
        grow = 1'b0;
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
